// File: rtl/pol2rec_seq.sv
// Sequential rotation-mode CORDIC: polar (16Q16 modulus, 8Q24 degrees) to rectangular 16Q16.
// One micro-rotation per clock through a shared arctangent table, with a start/busy/done handshake.
module pol2rec_seq #(
  parameter int unsigned NITER  = 32,
  parameter logic [31:0] K_GAIN = 32'h9B74EDA8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] mod,
  input  logic [31:0] angle,
  output logic        busy,
  output logic        done,
  output logic [31:0] x,
  output logic [31:0] y
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_e;

  localparam logic signed [33:0] DEG90  = 34'sh05A000000;
  localparam logic signed [33:0] DEG180 = 34'sh0B4000000;
  localparam logic signed [33:0] SAT_HI = 34'sh07FFFFFFF;
  localparam logic signed [33:0] SAT_LO = 34'sh380000000;
  localparam logic [5:0]         LAST   = 6'(NITER - 1);

  // atan(2^-i) in degrees, 8Q24
  function automatic logic [31:0] atan_rom(input logic [5:0] a);
    case (a)
      6'd0:  return 32'h2D000000;
      6'd1:  return 32'h1A90A732;
      6'd2:  return 32'h0E094741;
      6'd3:  return 32'h07200112;
      6'd4:  return 32'h03938AA6;
      6'd5:  return 32'h01CA3795;
      6'd6:  return 32'h00E52A1B;
      6'd7:  return 32'h007296D8;
      6'd8:  return 32'h00394BA5;
      6'd9:  return 32'h001CA5DA;
      6'd10: return 32'h000E52EE;
      6'd11: return 32'h00072977;
      6'd12: return 32'h000394BC;
      6'd13: return 32'h0001CA5E;
      6'd14: return 32'h0000E52F;
      6'd15: return 32'h00007297;
      6'd16: return 32'h0000394C;
      6'd17: return 32'h00001CA6;
      6'd18: return 32'h00000E53;
      6'd19: return 32'h00000729;
      6'd20: return 32'h00000395;
      6'd21: return 32'h000001CA;
      6'd22: return 32'h000000E5;
      6'd23: return 32'h00000073;
      6'd24: return 32'h00000039;
      6'd25: return 32'h0000001D;
      6'd26: return 32'h0000000E;
      6'd27: return 32'h00000007;
      6'd28: return 32'h00000004;
      6'd29: return 32'h00000002;
      6'd30: return 32'h00000001;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic [31:0] sat32(input logic signed [33:0] v);
    if (v > SAT_HI) return 32'h7FFFFFFF;
    if (v < SAT_LO) return 32'h80000000;
    return v[31:0];
  endfunction

  state_e             state_q, state_d;
  logic signed [33:0] xr_q, xr_d, yr_q, yr_d, zr_q, zr_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [31:0]        mod_q, mod_d, angle_q, angle_d;
  logic [31:0]        x_q, x_d, y_q, y_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic signed [64:0] mod_w, k_w, prod;
  logic signed [33:0] kmod, ang34, xs, ys, atan34;
  logic [31:0]        rom;

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    zr_d    = zr_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    angle_d = angle_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // signed modulus times unsigned 0Q32 gain; >>> 32 floors toward -inf
    mod_w  = {{33{mod_q[31]}}, mod_q};
    k_w    = {33'd0, K_GAIN};
    prod   = mod_w * k_w;
    kmod   = 34'(prod >>> 32);
    ang34  = {{2{angle_q[31]}}, angle_q};
    xs     = xr_q >>> cnt_q;
    ys     = yr_q >>> cnt_q;
    rom    = atan_rom(cnt_q);
    atan34 = {{2{rom[31]}}, rom};

    case (state_q)
      IDLE: begin
        if (start) begin
          mod_d   = mod;
          angle_d = angle;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // fold outer quadrants into CORDIC convergence range by pre-rotating 180 deg
        if (ang34 > DEG90) begin
          xr_d = -kmod;
          zr_d = ang34 - DEG180;
        end else if (ang34 < -DEG90) begin
          xr_d = -kmod;
          zr_d = ang34 + DEG180;
        end else begin
          xr_d = kmod;
          zr_d = ang34;
        end
        yr_d    = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        if (!zr_q[33]) begin
          xr_d = xr_q - ys;
          yr_d = yr_q + xs;
          zr_d = zr_q - atan34;
        end else begin
          xr_d = xr_q + ys;
          yr_d = yr_q - xs;
          zr_d = zr_q + atan34;
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        x_d     = sat32(xr_q);
        y_d     = sat32(yr_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      zr_q    <= '0;
      cnt_q   <= '0;
      mod_q   <= '0;
      angle_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      zr_q    <= zr_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      angle_q <= angle_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign x    = x_q;
  assign y    = y_q;

endmodule

// File: doc/pol2rec_seq.md
Name: pol2rec_seq

Overview:
- Sequential CORDIC in rotation mode. Converts a polar pair (modulus 16Q16, angle in degrees 8Q24) to rectangular X/Y (16Q16).
- It is the inverse companion of the vectoring-mode rec2pol block and shares the ATAN_ROM arctangent table (6-bit addr, 32-bit 8Q24 degrees, entry i = atan(2^-i)).
- Sits beside rec2pol in the coordinate-conversion datapath.
- Uses a start/busy/done handshake instead of an external enable.

Parameters:
- NITER, 32: number of CORDIC micro-rotations (1..32); sets ROM addresses 0..NITER-1.
- K_GAIN, 32'h9B74EDA8: unsigned 0Q32 CORDIC gain compensation, 0.607252935.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- start  in  1  one-cycle request; accepted only in IDLE.
- mod  in  32  signed modulus, 16Q16; captured on the accepted start.
- angle  in  32  signed angle in degrees, 8Q24, full range -128..+127.99; captured on the accepted start.
- busy  out  1  high from the cycle after an accepted start until done is asserted.
- done  out  1  one-cycle pulse when x/y update.
- x  out  32  signed X = mod*cos(angle), 16Q16, registered, held until the next done.
- y  out  32  signed Y = mod*sin(angle), 16Q16, registered, held until the next done.

Behaviour:
- Reset (reset==0 at clock edge): FSM to IDLE; x=0, y=0, busy=0, done=0; internal xr/yr/zr/counter cleared. Reset has priority over every other input, including mid-iteration. An aborted conversion produces no done.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE: start==1 captures mod and angle into registers, goes to LOAD, and sets busy. start==0 stays in IDLE.
- LOAD (1 cycle):
  - Internal width is 34 bits: xr, yr are 18Q16; zr is 10Q24.
  - Gain prescale: kmod = (mod * K_GAIN) >>> 32 as a signed × unsigned product, truncated toward -inf.
  - Quadrant fold using 90° = 34'sh05A000000 and 180° = 34'sh0B4000000:
    - angle > +90°: xr = -kmod, zr = angle - 180°.
    - angle < -90°: xr = -kmod, zr = angle + 180°.
    - otherwise: xr = kmod, zr = angle.
  - yr = 0 in all cases.
  - Counter i = 0. Go to ITER.
- ITER (NITER cycles, i = 0..NITER-1):
  - d = +1 if zr >= 0 (zr[33]==0), else -1.
  - xr <= xr - d*(yr >>> i)
  - yr <= yr + d*(xr >>> i)
  - zr <= zr - d*ATAN_ROM[i]; the ROM value is sign-extended to 34 bits.
  - Shifts are arithmetic. All three registers update from the previous-cycle values simultaneously.
  - After i == NITER-1, go to DONE.
- DONE (1 cycle):
  - x <= sat32(xr), y <= sat32(yr); saturate to 32'sh7FFFFFFF / 32'sh80000000 when the 34-bit value exceeds the 32-bit range.
  - done=1, busy=0. Return to IDLE.
- Latency: accepted start at edge 0 gives done high for the cycle after edge NITER+2. Throughput is one conversion per NITER+3 cycles; a start can be accepted the cycle after done.
- start while busy (LOAD/ITER/DONE): ignored, with no effect on the captured operands or the sequence.
- Negative mod: legal; the result is the point reflected through the origin.
- mod == 0: x = y = 0 exactly.
- Accuracy: |error| <= 8 LSB (16Q16) per component for |mod| <= 16384.0 with NITER = 32.
- x/y change only in the DONE state or on reset.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, no start -> x=0, y=0, busy=0, done never pulses.
- mod=0x00010000, angle=0 -> done exactly NITER+3 cycles after start is sampled; x=0x00010000±8, y=0x00000000±8; busy high for NITER+2 cycles.
- mod=0x00020000, angle=30° (0x1E000000) -> x=0x0001BB67±8, y=0x00010000±8.
- Quadrant fold:
  - mod=0x00010000, angle=120° (0x78000000) -> x=0xFFFF8000±8, y=0x0000DDB4±8.
  - angle=-90° (0xA6000000) -> x=0±8, y=0xFFFF0000±8.
  - angle=-120° (0x88000000) -> x=0xFFFF8000±8, y=0xFFFF224C±8.
- Handshake: pulse start again 5 cycles into ITER with different operands -> ignored; the first result appears unchanged with a single done pulse. A start on the cycle after done is accepted.
- Reset mid-operation: assert reset at i=10 -> next edge busy=0, done=0, x=y=0; no done follows. A new start afterwards converts correctly (mod=0x00010000, angle=45° (0x2D000000) -> x=y=0x0000B505±8).
